// File: rtl/sr_bank_ctrl.sv
// sr_bank_ctrl
//   Shares a bank of NBITS external SR flip-flops between NREQ requesters.
//   A round-robin arbiter grants one request at a time. The granted op is
//   issued as a single-cycle pulse on s_out (set) or r_out (clear). The
//   controller then checks the flop output on flag_q. On a mismatch it
//   re-drives the pulse up to MAX_RETRY times. After that it latches a
//   sticky error.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   req_valid  per-requester request pending
//   req_op     per-requester op: 1 = set, 0 = clear
//   req_idx    per-requester target bit, packed IDX_W bits per requester
//   req_ready  one-hot grant, only in IDLE; handshake = valid & ready
//   s_out      registered set lines to the flop bank
//   r_out      registered reset lines to the flop bank
//   flag_q     q outputs of the flop bank
//   done       one-cycle pulse when an operation has been verified
//   done_id    requester served, valid with done
//   err        sticky verify failure after all retries
//   err_idx    failing bit index, valid while err is high
//   err_clr    clears err; only acted on in ERR
//
// State   | meaning
// --------+---------------------------------------------------------
// IDLE    | arbitrate; grant one requester and launch its pulse
// DRIVE   | s_out/r_out carry the one-hot pulse for this cycle only
// WAIT    | lines released; flop has just sampled the pulse
// CHECK   | compare flag_q[idx] against op; finish, retry or fail
// ERR     | sticky error, no grants until err_clr

module sr_bank_ctrl #(
    parameter  int NREQ      = 4,
    parameter  int NBITS     = 8,
    parameter  int IDX_W     = 3,
    parameter  int MAX_RETRY = 2,
    localparam int ID_W      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_op,
    input  logic [NREQ*IDX_W-1:0] req_idx,
    output logic [NREQ-1:0]       req_ready,
    output logic [NBITS-1:0]      s_out,
    output logic [NBITS-1:0]      r_out,
    input  logic [NBITS-1:0]      flag_q,
    output logic                  done,
    output logic [ID_W-1:0]       done_id,
    output logic                  err,
    output logic [IDX_W-1:0]      err_idx,
    input  logic                  err_clr
);

    localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_ERR
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [RC_W-1:0] retry_cnt;
    logic [ID_W-1:0] cur_id;
    logic            cur_op;
    logic [IDX_W-1:0] cur_idx;

    logic [IDX_W-1:0] idx_arr [NREQ];
    logic [NREQ-1:0]  grant;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  nxt_ptr;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [ID_W:0]    rr_sum;
    logic [ID_W-1:0]  cand;
    logic             handshake;
    logic             verify_ok;

    function automatic logic [NBITS-1:0] bit_mask(input logic [IDX_W-1:0] idx);
        bit_mask = {{(NBITS-1){1'b0}}, 1'b1} << idx;
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_idx
        assign idx_arr[g] = req_idx[g*IDX_W +: IDX_W];
    end

    // Scan requesters starting at rr_ptr and wrap modulo NREQ.
    // rr_ptr < NREQ <= 2**ID_W, so one subtraction is enough to wrap.
    always_comb begin
        grant     = '0;
        win_id    = '0;
        win_idx   = '0;
        win_found = 1'b0;
        rr_sum    = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            rr_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (rr_sum >= (ID_W+1)'(NREQ)) begin
                rr_sum = rr_sum - (ID_W+1)'(NREQ);
            end
            cand = rr_sum[ID_W-1:0];
            if (!win_found && req_valid[cand]) begin
                win_found   = 1'b1;
                win_id      = cand;
                win_idx     = idx_arr[cand];
                grant[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        if (win_id == ID_W'(NREQ - 1)) begin
            nxt_ptr = '0;
        end else begin
            nxt_ptr = win_id + ID_W'(1);
        end
    end

    // Grants are suppressed while rst is asserted so nothing can handshake
    // into a controller that is being reset.
    assign req_ready = (rst && state == S_IDLE) ? grant : '0;
    assign handshake = |(req_valid & req_ready);
    assign verify_ok = (flag_q[cur_idx] == cur_op);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            retry_cnt <= '0;
            cur_id    <= '0;
            cur_op    <= 1'b0;
            cur_idx   <= '0;
            s_out     <= '0;
            r_out     <= '0;
            done      <= 1'b0;
            done_id   <= '0;
            err       <= 1'b0;
            err_idx   <= '0;
        end else begin
            // Pulse outputs default low, so each s/r pulse lasts exactly one cycle.
            s_out <= '0;
            r_out <= '0;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (handshake) begin
                        cur_id    <= win_id;
                        cur_op    <= req_op[win_id];
                        cur_idx   <= win_idx;
                        rr_ptr    <= nxt_ptr;
                        retry_cnt <= '0;
                        if (req_op[win_id]) begin
                            s_out <= bit_mask(win_idx);
                        end else begin
                            r_out <= bit_mask(win_idx);
                        end
                        state <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (verify_ok) begin
                        done    <= 1'b1;
                        done_id <= cur_id;
                        state   <= S_IDLE;
                    end else if (retry_cnt < RC_W'(MAX_RETRY)) begin
                        retry_cnt <= retry_cnt + RC_W'(1);
                        if (cur_op) begin
                            s_out <= bit_mask(cur_idx);
                        end else begin
                            r_out <= bit_mask(cur_idx);
                        end
                        state <= S_DRIVE;
                    end else begin
                        err     <= 1'b1;
                        err_idx <= cur_idx;
                        state   <= S_ERR;
                    end
                end
                S_ERR: begin
                    if (err_clr) begin
                        err   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Testbench for sr_bank_ctrl.
// Stimulus pushes the expected outcome of each granted op into a queue.
// A negedge monitor pops that queue on done or on a rising err and compares.
// The flop bank is modelled behaviourally. A configurable bit can ignore
// its first N pulses, which creates verify mismatches.

module tb_sr_bank_ctrl;
    localparam int NREQ      = 4;
    localparam int NBITS     = 8;
    localparam int IDX_W     = 3;
    localparam int MAX_RETRY = 2;
    localparam int ID_W      = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_op = '0;
    logic [NREQ*IDX_W-1:0] req_idx = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NBITS-1:0]      s_out;
    logic [NBITS-1:0]      r_out;
    logic [NBITS-1:0]      flag_q;
    logic                  done;
    logic [ID_W-1:0]       done_id;
    logic                  err;
    logic [IDX_W-1:0]      err_idx;
    logic                  err_clr = 1'b0;

    always #5 clk = ~clk;

    sr_bank_ctrl #(
        .NREQ(NREQ), .NBITS(NBITS), .IDX_W(IDX_W), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_idx(req_idx), .req_ready(req_ready), .s_out(s_out), .r_out(r_out),
        .flag_q(flag_q), .done(done), .done_id(done_id), .err(err),
        .err_idx(err_idx), .err_clr(err_clr)
    );

    typedef struct {
        bit is_err;
        int id;
        int idx;
        bit op;
        int cyc;
        int pulses;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout (cycle %0d)", name, cyc);
    endtask

    // Behavioural flop bank. A stuck bit shows stuck_val on flag_q until it
    // has received stuck_until pulses in total.
    logic [NBITS-1:0] q_bank = '0;
    int               hit_cnt [NBITS];
    int               stuck_bit = -1;
    int               stuck_until = 0;
    int               stuck_n = 0;
    bit               stuck_val = 1'b0;

    always @(posedge clk) begin
        for (int b = 0; b < NBITS; b++) begin
            if (s_out[b] || r_out[b]) begin
                hit_cnt[b] <= hit_cnt[b] + 1;
                q_bank[b]  <= s_out[b];
            end
        end
    end

    always_comb begin
        flag_q = q_bank;
        for (int b = 0; b < NBITS; b++) begin
            if (b == stuck_bit && hit_cnt[b] < stuck_until) flag_q[b] = stuck_val;
        end
    end

    task automatic set_fault(input int b, input bit val, input int n);
        stuck_bit   = b;
        stuck_val   = val;
        stuck_n     = n;
        stuck_until = hit_cnt[b] + n + 1;
    endtask

    // Reference model state: round-robin pointer, first cycle a new grant may
    // occur, and whether an error is outstanding.
    int model_rr = 0;
    int model_free = 0;
    bit model_err = 1'b0;
    int last_w = -1;
    bit drop_on_grant = 1'b1;
    int grant_log[$];
    int hs_log[$];

    function automatic int model_winner(input logic [NREQ-1:0] mask);
        for (int i = 0; i < NREQ; i++) begin
            if (mask[(model_rr + i) % NREQ]) return (model_rr + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic grant_model();
        logic [NREQ-1:0] exp_ready;
        int w, f, nfail;
        exp_t e;
        exp_ready = '0;
        w = -1;
        if (rst && !model_err && cyc >= model_free) begin
            w = model_winner(req_valid);
            if (w >= 0) exp_ready[w] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        if (req_ready != 0) begin
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_log.push_back(i);
            hs_log.push_back(cyc);
        end
        if (w >= 0) begin
            e.id  = w;
            e.op  = req_op[w];
            e.idx = int'(req_idx[w*IDX_W +: IDX_W]);
            f = (e.idx == stuck_bit && stuck_val != e.op) ? stuck_n : 0;
            e.is_err = (f > MAX_RETRY);
            nfail    = e.is_err ? MAX_RETRY : f;
            e.pulses = nfail + 1;
            e.cyc    = cyc + 4 + 3 * nfail;
            exp_q.push_back(e);
            model_rr = (w + 1) % NREQ;
            if (e.is_err) model_err = 1'b1;
            else model_free = e.cyc;
        end
        last_w = w;
    endtask

    task automatic step();
        @(negedge clk);
        grant_model();
        @(posedge clk);
        #1;
        if (drop_on_grant && last_w >= 0) req_valid = '0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        exp_q.delete();
        model_rr   = 0;
        model_free = 0;
        model_err  = 1'b0;
        repeat (n) step();
        rst = 1'b1;
    endtask

    task automatic wait_grant(input string name, input int budget);
        int t = 0;
        do begin
            step();
            t++;
        end while (last_w < 0 && t < budget);
        if (last_w < 0) fail_timeout(name);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            step();
            t++;
        end
        if (exp_q.size() != 0) begin
            fail_timeout(name);
            exp_q.delete();
        end
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        err_clr    = 1'b0;
        model_err  = 1'b0;
        model_free = cyc;
        chk("err_cleared", 32'(err), 0);
    endtask

    task automatic set_req(input int k, input bit op, input int idx);
        req_op[k] = op;
        req_idx[k*IDX_W +: IDX_W] = IDX_W'(idx);
    endtask

    // Monitor: checks pulses against the op at the head of the queue and
    // compares each completion with the popped expectation.
    int   pulse_cnt = 0;
    logic err_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        chk("s_and_r_overlap", 32'(s_out & r_out), 0);
        chk("pulse_onehot", 32'($countones(s_out | r_out) <= 1), 1);
        if (!rst) pulse_cnt = 0;
        if ((s_out | r_out) != 0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'(s_out | r_out), 0);
            end else begin
                e = exp_q[0];
                chk("s_out", 32'(s_out), e.op ? (32'd1 << e.idx) : 32'd0);
                chk("r_out", 32'(r_out), e.op ? 32'd0 : (32'd1 << e.idx));
                pulse_cnt++;
            end
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 0);
            end else begin
                e = exp_q.pop_front();
                chk("outcome_err_expected", 0, 32'(e.is_err));
                chk("done_id", 32'(done_id), e.id);
                chk("done_cycle", cyc, e.cyc);
                chk("done_pulses", pulse_cnt, e.pulses);
                chk("err_at_done", 32'(err), 0);
            end
            pulse_cnt = 0;
        end
        if (err && !err_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_err", 32'(err), 0);
            end else begin
                e = exp_q.pop_front();
                chk("outcome_err_expected", 1, 32'(e.is_err));
                chk("err_idx", 32'(err_idx), e.idx);
                chk("err_cycle", cyc, e.cyc);
                chk("err_pulses", pulse_cnt, e.pulses);
            end
            pulse_cnt = 0;
        end
        err_prev = err;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int mask, w, r, fcnt, t;
        // Reset with every requester asking.
        req_valid = '1;
        do_reset(2);
        chk("rst_s_out", 32'(s_out), 0);
        chk("rst_r_out", 32'(r_out), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_done_id", 32'(done_id), 0);
        chk("rst_err_idx", 32'(err_idx), 0);
        req_valid = '0;
        step();

        // Single set of bit 5 by requester 0.
        drop_on_grant = 1'b1;
        set_req(0, 1'b1, 5);
        req_valid = 4'b0001;
        wait_grant("single_grant", 10);
        wait_idle("single_done", 20);

        // Round robin with all requesters held.
        do_reset(1);
        for (int k = 0; k < NREQ; k++) set_req(k, 1'($urandom_range(0, 1)), $urandom_range(0, 7));
        drop_on_grant = 1'b0;
        grant_log.delete();
        hs_log.delete();
        req_valid = '1;
        t = 0;
        while (grant_log.size() < 5 && t < 60) begin
            step();
            t++;
        end
        req_valid = '0;
        drop_on_grant = 1'b1;
        if (grant_log.size() < 5) fail_timeout("rr_grants");
        for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("rr_order", grant_log[i], i % NREQ);
        for (int i = 1; i < 5 && i < hs_log.size(); i++) chk("rr_spacing", hs_log[i] - hs_log[i-1], 4);
        wait_idle("rr_done", 20);

        // Clear with one retry: bit 7 reads back 1 on the first check only.
        set_req(2, 1'b0, 7);
        set_fault(7, 1'b1, 1);
        req_valid = 4'b0100;
        wait_grant("retry_grant", 10);
        wait_idle("retry_done", 20);
        chk("retry_no_err", 32'(err), 0);
        stuck_bit = -1;

        // Permanent stuck-at-0 on bit 3 while setting it.
        set_req(1, 1'b1, 3);
        set_fault(3, 1'b0, 10);
        req_valid = 4'b0010;
        wait_grant("err_grant", 10);
        wait_idle("err_raise", 30);
        req_valid = '1;
        drop_on_grant = 1'b0;
        repeat (5) step();
        chk("err_sticky", 32'(err), 1);
        stuck_bit = -1;
        drop_on_grant = 1'b1;
        clear_err();
        wait_grant("after_clear_grant", 2);
        wait_idle("after_clear_done", 20);

        // Reset during WAIT abandons the op.
        set_req(3, 1'b1, 2);
        req_valid = 4'b1000;
        wait_grant("midop_grant", 10);
        step();
        do_reset(2);
        repeat (10) step();
        chk("midop_no_err", 32'(err), 0);
        req_valid = '1;
        wait_grant("midop_rr_reset", 2);
        wait_idle("midop_after", 20);

        // Randomised ops with occasional faults.
        for (int n = 0; n < 40; n++) begin
            mask = $urandom_range(1, (1 << NREQ) - 1);
            for (int k = 0; k < NREQ; k++) set_req(k, 1'($urandom_range(0, 1)), $urandom_range(0, 7));
            w = model_winner(NREQ'(mask));
            r = $urandom_range(0, 9);
            fcnt = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 4;
            if (fcnt > 0) set_fault(int'(req_idx[w*IDX_W +: IDX_W]), !req_op[w], fcnt);
            else stuck_bit = -1;
            req_valid = NREQ'(mask);
            wait_grant("rand_grant", 10);
            wait_idle("rand_done", 40);
            stuck_bit = -1;
            if (model_err) clear_err();
        end

        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
